posit_normalize_round_es2: RTL

Pipelined output stage that consumes the unnormalised-encoding sum produced by the ES=2 raw posit adder (sign, scale, normalised fraction, inf, zero, truncated flag). It packs that value into a standard NBITS-wide posit with ES=2 and rounds to nearest, ties to even. It sits directly downstream of the adder, behind its `done`/`truncated` outputs. It accepts one operand per cycle and carries a start/done valid bit alongside the data.

---
 rtl/posit_normalize_round_es2_if.sv | 24 ++
 rtl/posit_normalize_round_es2.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/posit_normalize_round_es2_if.sv
// Handshake and data bundle between the raw posit adder and the
// normalise/round output stage.
interface posit_normalize_round_es2_if #(
  parameter int NBITS = 32,
  parameter int FBITS = 30,
  parameter int SBITS = 8
);
  logic [1+SBITS+FBITS+2-1:0] in_sum;
  logic                       in_truncated;
  logic                       start;
  logic [NBITS-1:0]           result;
  logic                       done;
  logic                       inexact;

  modport master (
    output in_sum, in_truncated, start,
    input  result, done, inexact
  );

  modport slave (
    input  in_sum, in_truncated, start,
    output result, done, inexact
  );
endinterface

// File: rtl/posit_normalize_round_es2.sv
// Three-stage pipeline that packs the adder's {sgn, scale, fraction, inf,
// zero} sum into an NBITS posit with ES=2, rounding to nearest, ties to even.
module posit_normalize_round_es2 #(
  parameter int NBITS = 32,
  parameter int FBITS = 30,
  parameter int SBITS = 8
) (
  input logic clk,
  input logic reset_n,
  posit_normalize_round_es2_if.slave bus
);

  // Field buffer wide enough that the longest regime never pushes fraction
  // bits off the bottom, so sticky sees every discarded bit.
  localparam int W    = NBITS - 1 + FBITS + 4;
  localparam int MW   = NBITS - 1;
  localparam int PADW = W - FBITS - 3;
  localparam logic signed [SBITS-1:0] SAT_HI = SBITS'(4 * (NBITS - 2));
  localparam logic signed [SBITS-1:0] SAT_LO = SBITS'(-4 * (NBITS - 2));
  localparam logic [SBITS-1:0] LEAD_ONE = 1;
  localparam logic [MW-1:0]    MAG_ONE  = 1;

  logic                    in_sgn;
  logic signed [SBITS-1:0] in_scale;
  logic [FBITS-1:0]        in_frac;
  logic                    in_inf;
  logic                    in_zero;

  assign {in_sgn, in_scale, in_frac, in_inf, in_zero} = bus.in_sum;

  logic signed [SBITS-1:0] k;
  logic [SBITS-1:0]        lead;

  // Regime decode: lead is the count of identical leading regime bits
  // (k+1 ones, or -k zeros); the terminating bit comes after them.
  always_comb begin
    k    = in_scale >>> 2;
    lead = k[SBITS-1] ? -k : k + LEAD_ONE;
  end

  logic             s1_valid;
  logic             s1_sgn;
  logic [1:0]       s1_e;
  logic [FBITS-1:0] s1_frac;
  logic             s1_neg;
  logic [SBITS-1:0] s1_lead;
  logic             s1_inf;
  logic             s1_zero;
  logic             s1_trunc;
  logic             s1_sat_hi;
  logic             s1_sat_lo;

  // S1 valid bit; an X or a start during reset never launches an operand.
  always_ff @(posedge clk) begin
    if (!reset_n) s1_valid <= 1'b0;
    else          s1_valid <= (bus.start === 1'b1);
  end

  // S1 data: register decoded regime, exponent and special/saturation flags.
  always_ff @(posedge clk) begin
    s1_sgn    <= in_sgn;
    s1_e      <= in_scale[1:0];
    s1_frac   <= in_frac;
    s1_neg    <= k[SBITS-1];
    s1_lead   <= lead;
    s1_inf    <= in_inf;
    s1_zero   <= in_zero;
    s1_trunc  <= bus.in_truncated;
    s1_sat_hi <= (in_scale > SAT_HI);
    s1_sat_lo <= (in_scale < SAT_LO);
  end

  logic [W-1:0] tail;
  logic [W-1:0] field;

  // Assemble {regime, e, fraction} left-justified: shift the terminator and
  // payload right by the run of leading bits, then fill that run with ones
  // for positive k.
  always_comb begin
    tail  = {s1_neg, s1_e, s1_frac, {PADW{1'b0}}};
    field = (tail >> s1_lead) | (s1_neg ? {W{1'b0}} : ~({W{1'b1}} >> s1_lead));
  end

  logic          s2_valid;
  logic          s2_sgn;
  logic [MW-1:0] s2_mag;
  logic          s2_guard;
  logic          s2_sticky;
  logic          s2_inf;
  logic          s2_zero;
  logic          s2_sat_hi;
  logic          s2_sat_lo;

  // S2 valid bit follows S1 and is cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) s2_valid <= 1'b0;
    else          s2_valid <= s1_valid;
  end

  // S2 data: split the field into magnitude, guard and sticky.
  always_ff @(posedge clk) begin
    s2_sgn    <= s1_sgn;
    s2_mag    <= field[W-1 -: MW];
    s2_guard  <= field[W-MW-1];
    s2_sticky <= (|field[W-MW-2:0]) | s1_trunc;
    s2_inf    <= s1_inf;
    s2_zero   <= s1_zero;
    s2_sat_hi <= s1_sat_hi;
    s2_sat_lo <= s1_sat_lo;
  end

  logic             round_up;
  logic [MW-1:0]    mag_fin;
  logic             inexact_next;
  logic [NBITS-1:0] result_next;

  // Round to nearest even with a clamp at maxpos, saturate, apply sign,
  // then let NaR and zero override everything.
  always_comb begin
    round_up     = s2_guard & (s2_mag[0] | s2_sticky);
    mag_fin      = (round_up && !(&s2_mag)) ? s2_mag + MAG_ONE : s2_mag;
    inexact_next = s2_guard | s2_sticky;
    if (s2_sat_hi) begin
      mag_fin      = {MW{1'b1}};
      inexact_next = 1'b1;
    end else if (s2_sat_lo) begin
      mag_fin      = MAG_ONE;
      inexact_next = 1'b1;
    end
    result_next = s2_sgn ? -{1'b0, mag_fin} : {1'b0, mag_fin};
    if (s2_inf) begin
      result_next  = {1'b1, {MW{1'b0}}};
      inexact_next = 1'b0;
    end else if (s2_zero) begin
      result_next  = {NBITS{1'b0}};
      inexact_next = 1'b0;
    end
  end

  logic             done_q;
  logic [NBITS-1:0] result_q;
  logic             inexact_q;

  // S3 output registers with defined reset values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done_q    <= 1'b0;
      result_q  <= {NBITS{1'b0}};
      inexact_q <= 1'b0;
    end else begin
      done_q    <= s2_valid;
      result_q  <= result_next;
      inexact_q <= inexact_next;
    end
  end

  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.inexact = inexact_q;

endmodule
